// File: rtl/db_fsm_multi.sv
// Multi-channel switch debouncer: one shared sample-tick prescaler, one 4-state FSM
// plus stability counter per channel. Define DB_SYNC_EN to add a per-channel input synchroniser.
module db_fsm_multi #(
  parameter int CH           = 4,
  parameter int DIV_BITS     = 19,
  parameter int STABLE_TICKS = 3,
  parameter int SYNC_STAGES  = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CH-1:0] sw,
  output logic [CH-1:0] db,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall,
  output logic          tick
);

  localparam int CNT_W = $clog2(STABLE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);
  localparam bit PARAMS_OK = (CH >= 1) && (DIV_BITS >= 2) && (STABLE_TICKS >= 1) &&
                             (SYNC_STAGES >= 2);

  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b10,
    WAIT0 = 2'b11
  } state_e;

  if (!PARAMS_OK) begin : g_param_check
    $error("db_fsm_multi: illegal parameter value");
  end

  // Shared prescaler: tick is high for the one cycle in which q is all-ones.
  logic [DIV_BITS-1:0] q_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q_q <= '0;
    else       q_q <= q_q + 1'b1;
  end

  assign tick = &q_q;

  logic [CH-1:0] s;

`ifdef DB_SYNC_EN
  logic [SYNC_STAGES-1:0] sync_q [CH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CH; i++) sync_q[i] <= '0;
    end else begin
      for (int i = 0; i < CH; i++) sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], sw[i]};
    end
  end

  always_comb begin
    for (int i = 0; i < CH; i++) s[i] = sync_q[i][SYNC_STAGES-1];
  end
`else
  assign s = sw;
`endif

  for (genvar i = 0; i < CH; i++) begin : g_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_q, rise_q, fall_q;

    // NOTE: next-state defaults are assigned first so no path through the case infers a latch.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
        ZERO: begin
          if (s[i]) begin
            state_d = WAIT1;
            cnt_d   = '0;
          end
        end
        WAIT1: begin
          if (!s[i])                state_d = ZERO;
          else if (tick) begin
            if (cnt_q == CNT_LAST) state_d = ONE;
            else                   cnt_d   = cnt_q + 1'b1;
          end
        end
        ONE: begin
          if (!s[i]) begin
            state_d = WAIT0;
            cnt_d   = '0;
          end
        end
        WAIT0: begin
          if (s[i])                 state_d = ONE;
          else if (tick) begin
            if (cnt_q == CNT_LAST) state_d = ZERO;
            else                   cnt_d   = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ZERO;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs are derived from the transition being taken, so db, rise and fall
    // all change on the same edge as the state.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= ZERO;
        cnt_q   <= '0;
        db_q    <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        db_q    <= (state_d == ONE) || (state_d == WAIT0);
        rise_q  <= (state_q == WAIT1) && (state_d == ONE);
        fall_q  <= (state_q == WAIT0) && (state_d == ZERO);
      end
    end

    assign db[i]   = db_q;
    assign rise[i] = rise_q;
    assign fall[i] = fall_q;
  end

endmodule

// File: tb/tb_db_fsm_multi.sv
// Directed bench for db_fsm_multi (CH=4, DIV_BITS=4, STABLE_TICKS=3); cycle 0 is the
// cycle in which reset releases, so ticks fall in cycles 15, 31, 47, ...
module tb_db_fsm_multi;

  localparam int CH = 4;
`ifdef DB_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic [CH-1:0] sw    = '0;
  logic [CH-1:0] db, rise, fall;
  logic          tick;

  db_fsm_multi #(
    .CH          (CH),
    .DIV_BITS    (4),
    .STABLE_TICKS(3),
    .SYNC_STAGES (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .sw   (sw),
    .db   (db),
    .rise (rise),
    .fall (fall),
    .tick (tick)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int rise_cnt [CH];
  int fall_cnt [CH];
  int last_rise[CH];
  int last_fall[CH];
  int tick_cnt, tick_bad, both_cnt, db_nz, db0_low;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic sample();
    for (int i = 0; i < CH; i++) begin
      if (rise[i] === 1'b1) begin
        rise_cnt[i]++;
        last_rise[i] = cyc;
      end
      if (fall[i] === 1'b1) begin
        fall_cnt[i]++;
        last_fall[i] = cyc;
      end
    end
    if ((rise & fall) !== '0) both_cnt++;
    if (db !== '0) db_nz++;
    if (db[0] !== 1'b1) db0_low++;
    if (tick === 1'b1) tick_cnt++;
    if (tick !== ((cyc % 16) == 15)) tick_bad++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    sample();
  endtask

  task automatic step_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset(input logic [CH-1:0] sw_init);
    reset = 1'b1;
    sw    = sw_init;
    repeat (2) @(posedge clk);
    #1;
    check("rst_db", db, 0);
    check("rst_rise", rise, 0);
    check("rst_fall", fall, 0);
    check("rst_tick", tick, 0);
    #1;
    reset = 1'b0;
    cyc   = 0;
    for (int i = 0; i < CH; i++) begin
      rise_cnt[i]  = 0;
      fall_cnt[i]  = 0;
      last_rise[i] = -1;
      last_fall[i] = -1;
    end
    tick_cnt = 0;
    tick_bad = 0;
    both_cnt = 0;
    db_nz    = 0;
    db0_low  = 0;
    sample();
  endtask

  function automatic int sum_rise();
    int t = 0;
    for (int i = 0; i < CH; i++) t += rise_cnt[i];
    return t;
  endfunction

  function automatic int sum_fall();
    int t = 0;
    for (int i = 0; i < CH; i++) t += fall_cnt[i];
    return t;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int low_base;

    // Idle: inputs low, only the tick moves.
    do_reset(4'h0);
    step_to(200);
    check("idle_rise", sum_rise(), 0);
    check("idle_fall", sum_fall(), 0);
    check("idle_db", db_nz, 0);
    check("idle_tick_cnt", tick_cnt, 12);
    check("idle_tick_phase", tick_bad, 0);

    // Rise on ch0; ch2 reverts in the tick cycle that would have qualified it.
    do_reset(4'h0);
    step_to(1);
    sw = 4'b0101;
    step_to(47 - LAT);
    sw[2] = 1'b0;
    step_to(47);
    check("rise_db_47", db, 4'b0000);
    check("rise_pulse_47", rise, 4'b0000);
    step_to(48);
    check("rise_pulse_48", rise, 4'b0001);
    check("rise_db_48", db, 4'b0001);
    step_to(49);
    check("rise_pulse_49", rise, 4'b0000);
    check("rise_db_49", db, 4'b0001);
    check("rise_cnt0", rise_cnt[0], 1);
    check("rise_cyc0", last_rise[0], 48);
    check("revert_wins_ch2", rise_cnt[2], 0);

    // Glitch low for 20 cycles on ch0, then a real release.
    low_base = db0_low;
    step_to(50);
    sw[0] = 1'b0;
    step_to(70);
    sw[0] = 1'b1;
    step_to(80);
    check("glitch_fall", fall_cnt[0], 0);
    check("glitch_db_low", db0_low - low_base, 0);
    sw[0] = 1'b0;
    step_to(127);
    check("fall_db_127", db, 4'b0001);
    check("fall_pulse_127", fall, 4'b0000);
    step_to(128);
    check("fall_pulse_128", fall, 4'b0001);
    check("fall_db_128", db, 4'b0000);
    step_to(130);
    check("fall_cnt0", fall_cnt[0], 1);
    check("fall_cyc0", last_fall[0], 128);
    check("no_rise_fall_both", both_cnt, 0);

    // All channels bouncing every 10 cycles, then held high.
    do_reset(4'h0);
    step_to(1);
    for (int k = 0; k < 30; k++) begin
      sw = (k % 2 == 0) ? 4'hF : 4'h0;
      step_to(1 + 10 * (k + 1));
    end
    sw = 4'h0;
    step_to(305);
    check("bounce_rise", sum_rise(), 0);
    check("bounce_fall", sum_fall(), 0);
    check("bounce_db", db_nz, 0);
    sw = 4'hF;
    step_to(351);
    check("hold_db_351", db, 4'h0);
    step_to(352);
    check("hold_rise_352", rise, 4'hF);
    check("hold_db_352", db, 4'hF);
    step_to(353);
    check("hold_rise_353", rise, 4'h0);
    check("hold_rise_total", sum_rise(), 4);

    // Reset while ch1 is in WAIT1 with cnt=2 and ch3 is already high.
    do_reset(4'b1000);
    step_to(49);
    check("pre_rst_rise3", last_rise[3], 48);
    sw = 4'b1010;
    step_to(85);
    check("pre_rst_db", db, 4'b1000);
    reset = 1'b1;
    #1;
    check("async_clr_db", db, 4'b0000);
    do_reset(4'b1010);
    step_to(16);
    check("requal_db_16", db, 4'b0000);
    step_to(32);
    check("requal_db_32", db, 4'b0000);
    step_to(47);
    check("requal_db_47", db, 4'b0000);
    check("requal_early_rise", sum_rise(), 0);
    step_to(48);
    check("requal_rise_48", rise, 4'b1010);
    check("requal_db_48", db, 4'b1010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
